// File: rtl/smc_cfreg_wr.sv
// Writable SMC configuration register. Host writes are staged and committed to the active config only while the SMC is idle.
// Optional feature: define SMC_CFG_LOCK_EN to make a committed bit 30 == 0 lock the register until reset.
module smc_cfreg_wr #(
  parameter logic [31:0] CFG_RESET = 32'hC000_0001,
  parameter logic [31:0] WR_MASK   = 32'h7FFF_FFFF
) (
  input  logic        hclk,
  input  logic        n_sys_reset,
  input  logic        selreg,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  input  logic        smc_idle,
  output logic [31:0] rdata,
  output logic        rd_valid,
  output logic [31:0] smc_config,
  output logic        cfg_pending,
  output logic        cfg_update,
  output logic        wr_err,
  output logic        dbg_state
);

  // Handshake: an access is taken on any rising edge where selreg and its strobe are high;
  // there is no back-pressure, results appear on the cycle after the accepting edge.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cfg_q, cfg_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] rdata_q;
  logic        rd_valid_q;
  logic        update_q;
  logic        commit;
  logic        locked;
  logic        wr_req, wr_acc, rd_acc;
  logic [31:0] bmask, merge_base, merged;

`ifdef SMC_CFG_LOCK_EN
  assign locked = ~cfg_q[30];
`else
  assign locked = 1'b0;
`endif

  assign wr_req = wr_en & selreg;
  assign wr_acc = wr_req & ~locked;
  assign rd_acc = rd_en & selreg;

  // Successive writes while pending accumulate on the staged value, not on the committed one.
  assign bmask      = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  assign merge_base = (state_q == ST_PEND) ? pend_q : cfg_q;
  assign merged     = (((merge_base & ~bmask) | (wdata & bmask)) & WR_MASK)
                    | (CFG_RESET & ~WR_MASK);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cfg_d   = cfg_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_acc) begin
          pend_d  = merged;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        // A commit and a write in the same cycle: commit the old staged value, keep the new one pending.
        if (smc_idle) begin
          commit  = 1'b1;
          cfg_d   = pend_q;
          state_d = wr_acc ? ST_PEND : ST_IDLE;
        end
        if (wr_acc) begin
          pend_d = merged;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge n_sys_reset) begin
    if (!n_sys_reset) begin
      state_q    <= ST_IDLE;
      cfg_q      <= CFG_RESET;
      pend_q     <= CFG_RESET;
      rdata_q    <= 32'h0;
      rd_valid_q <= 1'b0;
      update_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      pend_q     <= pend_d;
      rdata_q    <= rd_acc ? cfg_q : 32'h0;
      rd_valid_q <= rd_acc;
      update_q   <= commit;
    end
  end

`ifdef SMC_CFG_LOCK_EN
  logic wr_err_q;
  always_ff @(posedge hclk or negedge n_sys_reset) begin
    if (!n_sys_reset) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_req & locked;
    end
  end
  assign wr_err = wr_err_q;
`else
  assign wr_err = 1'b0;
`endif

  assign rdata       = rdata_q;
  assign rd_valid    = rd_valid_q;
  assign smc_config  = cfg_q;
  assign cfg_pending = (state_q == ST_PEND);
  assign cfg_update  = update_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_smc_cfreg_wr.sv
// Bench for smc_cfreg_wr: directed scenarios followed by random traffic against a staged/committed reference model.
module tb_smc_cfreg_wr;

  localparam logic [31:0] CFG_RESET_V = 32'hC000_0001;
  localparam logic [31:0] WR_MASK_V   = 32'h7FFF_FFFF;
`ifdef SMC_CFG_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic        hclk = 1'b0;
  logic        n_sys_reset;
  logic        selreg, wr_en, rd_en, smc_idle;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [31:0] rdata, smc_config;
  logic        rd_valid, cfg_pending, cfg_update, wr_err, dbg_state;

  smc_cfreg_wr dut (
    .hclk        (hclk),
    .n_sys_reset (n_sys_reset),
    .selreg      (selreg),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .wstrb       (wstrb),
    .wdata       (wdata),
    .smc_idle    (smc_idle),
    .rdata       (rdata),
    .rd_valid    (rd_valid),
    .smc_config  (smc_config),
    .cfg_pending (cfg_pending),
    .cfg_update  (cfg_update),
    .wr_err      (wr_err),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 hclk = ~hclk;

  int total = 0;
  int bad   = 0;

  // reference model: committed value, at most one staged value, expected read data queue
  logic [31:0] m_cfg;
  logic [31:0] staged_q[$];
  logic [31:0] exp_q[$];
  logic        e_rdv, e_upd, e_err;

  function automatic logic [31:0] apply_write(input logic [31:0] base, input logic [31:0] data,
                                              input logic [3:0] strb);
    logic [31:0] r;
    r = base;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    for (int i = 0; i < 32; i++)
      if (!WR_MASK_V[i]) r[i] = CFG_RESET_V[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cfg = CFG_RESET_V;
    staged_q.delete();
    exp_q.delete();
    e_rdv = 1'b0;
    e_upd = 1'b0;
    e_err = 1'b0;
  endtask

  task automatic model_step();
    logic        locked, wreq, racc, commit;
    logic [31:0] new_c, base;
    locked = LOCK && !m_cfg[30];
    wreq   = wr_en && selreg;
    racc   = rd_en && selreg;
    e_rdv  = racc;
    if (racc) exp_q.push_back(m_cfg);
    e_err  = wreq && locked;
    commit = (staged_q.size() != 0) && smc_idle;
    e_upd  = commit;
    new_c  = commit ? staged_q[0] : m_cfg;
    if (wreq && !locked) begin
      base = (staged_q.size() != 0) ? staged_q[0] : m_cfg;
      staged_q.delete();
      staged_q.push_back(apply_write(base, wdata, wstrb));
    end else if (commit) begin
      staged_q.delete();
    end
    m_cfg = new_c;
  endtask

  // scoreboard check of every output against the model
  task automatic check_outputs();
    logic [31:0] exp_rd;
    exp_rd = 32'h0;
    if (e_rdv && exp_q.size() != 0) exp_rd = exp_q.pop_front();
    chk("smc_config",  smc_config,         m_cfg);
    chk("cfg_pending", {31'h0, cfg_pending}, {31'h0, staged_q.size() != 0});
    chk("cfg_update",  {31'h0, cfg_update},  {31'h0, e_upd});
    chk("rd_valid",    {31'h0, rd_valid},    {31'h0, e_rdv});
    chk("wr_err",      {31'h0, wr_err},      {31'h0, e_err});
    chk("rdata",       rdata,              exp_rd);
  endtask

  // driver: apply inputs away from the edge, clock once, then check
  task automatic cycle(input logic w, input logic r, input logic s, input logic [3:0] strb,
                       input logic [31:0] data, input logic idle);
    selreg   = s;
    wr_en    = w;
    rd_en    = r;
    wstrb    = strb;
    wdata    = data;
    smc_idle = idle;
    @(posedge hclk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cfg"},     smc_config,           32'hC000_0001);
    chk({tag, "_rdata"},   rdata,                32'h0);
    chk({tag, "_rdvalid"}, {31'h0, rd_valid},    32'h0);
    chk({tag, "_pending"}, {31'h0, cfg_pending}, 32'h0);
    chk({tag, "_update"},  {31'h0, cfg_update},  32'h0);
    chk({tag, "_wrerr"},   {31'h0, wr_err},      32'h0);
  endtask

  task automatic mid_reset(input string tag);
    #2 n_sys_reset = 1'b0;
    #1 check_reset_values(tag);
    model_reset();
    @(negedge hclk);
    n_sys_reset = 1'b1;
  endtask

  initial begin
    n_sys_reset = 1'b0;
    selreg = 0; wr_en = 0; rd_en = 0; wstrb = 4'h0; wdata = 32'h0; smc_idle = 1'b1;
    model_reset();
    #12 check_reset_values("por");
    @(negedge hclk);
    n_sys_reset = 1'b1;

    // 1: read after reset
    cycle(0, 1, 1, 4'h0, 32'h0, 1);
    chk("t1_rdata", rdata, 32'hC000_0001);
    chk("t1_rdv", {31'h0, rd_valid}, 32'h1);

    // 2: single byte write with the SMC idle
    cycle(1, 0, 1, 4'b0001, 32'h0000_00AB, 1);
    cycle(0, 0, 1, 4'h0, 32'h0, 1);
    chk("t2_cfg", smc_config, 32'hC000_00AB);
    chk("t2_upd", {31'h0, cfg_update}, 32'h1);
    cycle(0, 0, 1, 4'h0, 32'h0, 1);

    // 3: accumulate two byte writes while busy, then commit
    cycle(1, 0, 1, 4'b0001, 32'h0000_0011, 0);
    cycle(1, 0, 1, 4'b0010, 32'h0000_2200, 0);
    cycle(0, 0, 1, 4'h0, 32'h0, 0);
    chk("t3_pend", {31'h0, cfg_pending}, 32'h1);
    chk("t3_hold", smc_config, 32'hC000_00AB);
    cycle(0, 0, 1, 4'h0, 32'h0, 1);
    chk("t3_cfg", smc_config, 32'hC000_2211);

    // 4: write all ones with a simultaneous read
    cycle(1, 1, 1, 4'hF, 32'hFFFF_FFFF, 0);
    chk("t4_old", rdata, 32'hC000_2211);
    cycle(0, 0, 1, 4'h0, 32'h0, 1);
    cycle(0, 1, 1, 4'h0, 32'h0, 1);
    chk("t4_new", rdata, 32'hFFFF_FFFF);

    // empty strobe still commits and pulses update
    cycle(1, 0, 1, 4'h0, 32'h1234_5678, 1);
    cycle(0, 0, 1, 4'h0, 32'h0, 1);
    chk("strb0_upd", {31'h0, cfg_update}, 32'h1);
    chk("strb0_cfg", smc_config, 32'hFFFF_FFFF);

    // unselected write is ignored
    cycle(1, 1, 0, 4'hF, 32'h0, 1);
    cycle(0, 0, 0, 4'h0, 32'h0, 1);

    // 5: reset with a write pending and the SMC busy
    cycle(1, 0, 1, 4'hF, 32'h0BAD_F00D, 0);
    cycle(0, 0, 1, 4'h0, 32'h0, 0);
    mid_reset("t5");
    cycle(0, 0, 1, 4'h0, 32'h0, 1);
    chk("t5_lost", smc_config, 32'hC000_0001);

`ifdef SMC_CFG_LOCK_EN
    // 6: clearing bit 30 commits, then further writes are rejected
    cycle(1, 0, 1, 4'hF, 32'h0000_0001, 1);
    cycle(0, 0, 1, 4'h0, 32'h0, 1);
    chk("t6_cfg", smc_config, 32'h8000_0001);
    cycle(1, 0, 1, 4'hF, 32'h4000_00FF, 1);
    chk("t6_err", {31'h0, wr_err}, 32'h1);
    chk("t6_nopend", {31'h0, cfg_pending}, 32'h0);
    cycle(0, 0, 1, 4'h0, 32'h0, 1);
    chk("t6_noupd", {31'h0, cfg_update}, 32'h0);
    chk("t6_keep", smc_config, 32'h8000_0001);
    mid_reset("t6rst");
`endif

    // random traffic, with one reset in the middle
    for (int k = 0; k < 600; k++) begin
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 4) != 0,
            4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 2) == 0);
      if (k == 300) begin
        mid_reset("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
